adat_decoder: RTL and testbench

Receives an NRZI-encoded ADAT bitstream, one bit per `adat_valid_i` strobe, and writes the 24-bit samples of all 8 channels into the `channel_buffer` RAM. The RAM layout is the one `adat_encoder` reads, so encoder→decoder loopback and the receive path share one buffer format. The block locks onto the sync pattern, checks every separator bit, and publishes the index of the last fully received good frame and its user bits. Clock recovery and oversampling happen upstream; this block runs at system clock with a bit-valid strobe.

---
 rtl/adat_decoder.sv | 214 +++++++++++++++++++++
 tb/tb_adat_decoder.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adat_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : adat_decoder
//  Description : ADAT receive path. NRZI-decodes one line bit per valid
//                strobe, locks onto the 10-zero sync pattern, checks every
//                separator bit, and writes the 24-bit samples of all 8
//                channels into a bit-wide circular frame buffer. The buffer
//                layout is {slot, channel[2:0], bitpos[4:0]}, which is the
//                layout adat_encoder reads.
//  Ports       : clk_i, rst_ni (synchronous, active low)
//                adat_i / adat_valid_i         - line level and bit strobe
//                write_data_o / write_addr_o / wr_en_o - buffer write port
//                last_good_frame_idx_o / user_bits_o   - newest good frame
//                frame_done_o (pulse), locked_o
//                err_cnt_o (only with ADAT_DECODER_ERR_CNT_EN defined)
//  Options     : ADAT_DECODER_ERR_CNT_EN - adds a 16-bit saturating count
//                of framing errors on err_cnt_o.
//  Revision    : 1.0 - initial release
// ============================================================================
module adat_decoder #(
    parameter int CIRC_BUF_BITS = 3,
    parameter int SYNC_ZEROS    = 10
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       adat_i,
    input  logic                       adat_valid_i,
    output logic                       write_data_o,
    output logic [CIRC_BUF_BITS+7:0]   write_addr_o,
    output logic                       wr_en_o,
    output logic [CIRC_BUF_BITS-1:0]   last_good_frame_idx_o,
    output logic [3:0]                 user_bits_o,
    output logic                       frame_done_o,
`ifdef ADAT_DECODER_ERR_CNT_EN
    output logic [15:0]                err_cnt_o,
`endif
    output logic                       locked_o
);

    localparam logic [3:0] c_sync_zeros = 4'(SYNC_ZEROS);

    typedef enum logic [2:0] {
        S_HUNT  = 3'd0,
        S_USER  = 3'd1,
        S_DATA  = 3'd2,
        S_TRAIL = 3'd3,
        S_SYNC  = 3'd4
    } state_t;

    state_t                      r_state;
    logic                        r_prev_level;
    logic [3:0]                  r_zero_cnt;     // consecutive decoded zeros, saturating
    logic [3:0]                  r_user_shadow;
    logic [1:0]                  r_user_cnt;
    logic [2:0]                  r_chan;
    logic [2:0]                  r_nib;
    logic [2:0]                  r_sub;          // 0 = separator, 1..4 = nibble bits
    logic [CIRC_BUF_BITS-1:0]    r_slot;

    logic                        r_write_data;
    logic [CIRC_BUF_BITS+7:0]    r_write_addr;
    logic                        r_wr_en;
    logic [CIRC_BUF_BITS-1:0]    r_last_good;
    logic [3:0]                  r_user_bits;
    logic                        r_frame_done;
    logic                        r_locked;

    logic                        w_bit;
    logic [1:0]                  w_k;
    logic [4:0]                  w_bitpos;
    logic                        w_error;

    assign w_bit    = adat_i ^ r_prev_level;
    // r_sub runs 1..4 over the data bits; its low two bits minus one give 0..3
    assign w_k      = r_sub[1:0] - 2'd1;
    assign w_bitpos = {r_nib, 2'b00} + {3'b000, w_k};

    // The zero counter tracks the run length in every state, so the SYNC
    // window checks reuse it: a 1 must close exactly c_sync_zeros zeros.
    always_comb begin
        w_error = 1'b0;
        if (adat_valid_i) begin
            case (r_state)
                S_DATA:  w_error = (r_sub == 3'd0) && !w_bit;
                S_TRAIL: w_error = !w_bit;
                S_SYNC:  w_error = w_bit ? (r_zero_cnt != c_sync_zeros)
                                         : (r_zero_cnt == c_sync_zeros);
                default: w_error = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state       <= S_HUNT;
            r_prev_level  <= 1'b0;
            r_zero_cnt    <= '0;
            r_user_shadow <= '0;
            r_user_cnt    <= '0;
            r_chan        <= '0;
            r_nib         <= '0;
            r_sub         <= '0;
            r_slot        <= '0;
            r_write_data  <= 1'b0;
            r_write_addr  <= '0;
            r_wr_en       <= 1'b0;
            r_last_good   <= '0;
            r_user_bits   <= '0;
            r_frame_done  <= 1'b0;
            r_locked      <= 1'b0;
        end else begin
            r_wr_en      <= 1'b0;
            r_frame_done <= 1'b0;
            if (adat_valid_i) begin
                r_prev_level <= adat_i;
                if (w_bit) begin
                    r_zero_cnt <= '0;
                end else if (r_zero_cnt != 4'hF) begin
                    r_zero_cnt <= r_zero_cnt + 4'd1;
                end

                if (w_error) begin
                    // Slot is kept: the next good frame overwrites the partial data.
                    r_state       <= S_HUNT;
                    r_locked      <= 1'b0;
                    r_user_shadow <= '0;
                end else begin
                    case (r_state)
                        S_HUNT: begin
                            if (w_bit && r_zero_cnt == c_sync_zeros) begin
                                r_state    <= S_USER;
                                r_user_cnt <= '0;
                            end
                        end
                        S_USER: begin
                            r_user_shadow <= {r_user_shadow[2:0], w_bit};
                            r_user_cnt    <= r_user_cnt + 2'd1;
                            if (r_user_cnt == 2'd3) begin
                                r_state <= S_DATA;
                                r_chan  <= '0;
                                r_nib   <= '0;
                                r_sub   <= '0;
                            end
                        end
                        S_DATA: begin
                            if (r_sub == 3'd0) begin
                                r_sub <= 3'd1;
                            end else begin
                                r_wr_en      <= 1'b1;
                                r_write_data <= w_bit;
                                r_write_addr <= {r_slot, r_chan, w_bitpos};
                                if (r_sub == 3'd4) begin
                                    r_sub <= 3'd0;
                                    if (r_nib == 3'd5) begin
                                        r_nib <= 3'd0;
                                        if (r_chan == 3'd7) begin
                                            r_state <= S_TRAIL;
                                        end else begin
                                            r_chan <= r_chan + 3'd1;
                                        end
                                    end else begin
                                        r_nib <= r_nib + 3'd1;
                                    end
                                end else begin
                                    r_sub <= r_sub + 3'd1;
                                end
                            end
                        end
                        S_TRAIL: begin
                            r_last_good  <= r_slot;
                            r_user_bits  <= r_user_shadow;
                            r_frame_done <= 1'b1;
                            r_locked     <= 1'b1;
                            r_slot       <= r_slot + 1'b1;
                            r_state      <= S_SYNC;
                        end
                        S_SYNC: begin
                            // Errors were filtered above, so a 1 here closes a valid sync run.
                            if (w_bit) begin
                                r_state    <= S_USER;
                                r_user_cnt <= '0;
                            end
                        end
                        default: r_state <= S_HUNT;
                    endcase
                end
            end
        end
    end

`ifdef ADAT_DECODER_ERR_CNT_EN
    logic [15:0] r_err_cnt;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_err_cnt <= '0;
        end else if (w_error && r_err_cnt != 16'hFFFF) begin
            r_err_cnt <= r_err_cnt + 16'd1;
        end
    end

    assign err_cnt_o = r_err_cnt;
`endif

    assign write_data_o          = r_write_data;
    assign write_addr_o          = r_write_addr;
    assign wr_en_o               = r_wr_en;
    assign last_good_frame_idx_o = r_last_good;
    assign user_bits_o           = r_user_bits;
    assign frame_done_o          = r_frame_done;
    assign locked_o              = r_locked;

endmodule
`default_nettype wire

// File: tb/tb_adat_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_adat_decoder
//  Description : Self-checking bench for adat_decoder. Frames are built from
//                a known per-slot image, NRZI-encoded and streamed in; the
//                captured buffer writes and status outputs are compared
//                against a table of hand-computed expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_adat_decoder;

    localparam int CIRC_BUF_BITS = 3;
    localparam int SYNC_ZEROS    = 10;
    localparam int AW            = CIRC_BUF_BITS + 8;
    localparam int NV            = 15;

    logic                      clk_i = 1'b0;
    logic                      rst_ni = 1'b0;
    logic                      adat_i = 1'b0;
    logic                      adat_valid_i = 1'b0;
    logic                      write_data_o;
    logic [AW-1:0]             write_addr_o;
    logic                      wr_en_o;
    logic [CIRC_BUF_BITS-1:0]  last_good_frame_idx_o;
    logic [3:0]                user_bits_o;
    logic                      frame_done_o;
    logic                      locked_o;
`ifdef ADAT_DECODER_ERR_CNT_EN
    logic [15:0]               err_cnt_o;
`endif

    adat_decoder #(
        .CIRC_BUF_BITS (CIRC_BUF_BITS),
        .SYNC_ZEROS    (SYNC_ZEROS)
    ) dut (
        .clk_i                 (clk_i),
        .rst_ni                (rst_ni),
        .adat_i                (adat_i),
        .adat_valid_i          (adat_valid_i),
        .write_data_o          (write_data_o),
        .write_addr_o          (write_addr_o),
        .wr_en_o               (wr_en_o),
        .last_good_frame_idx_o (last_good_frame_idx_o),
        .user_bits_o           (user_bits_o),
        .frame_done_o          (frame_done_o),
`ifdef ADAT_DECODER_ERR_CNT_EN
        .err_cnt_o             (err_cnt_o),
`endif
        .locked_o              (locked_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [3:0] user;
        int         nz;
        int         bad;        // separator group forced to 0, -1 for none
        int         key;
        logic       exp_done;
        logic       exp_locked;
        logic [2:0] exp_idx;
        logic [3:0] exp_user;
    } vec_t;

    vec_t vecs [NV];

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   wr_count = 0;
    int   hi_writes = 0;
    int   done_count = 0;
    int   last_done_cyc = 0;
    bit   jitter = 1'b0;
    logic line = 1'b0;
    logic ram [0:(1<<AW)-1];

    always @(posedge clk_i) cyc <= cyc + 1;

    always @(negedge clk_i) begin
        if (wr_en_o) begin
            ram[write_addr_o] = write_data_o;
            wr_count++;
            if (write_addr_o[4:0] >= 5'd24) hi_writes++;
        end
        if (frame_done_o) done_count++;
    end

    function automatic logic [23:0] img(input int key, input int ch);
        logic [31:0] v;
        v = ((32'(key) + 32'd1) * 32'h9E3779B1) ^ ((32'(ch) + 32'd1) * 32'h85EBCA6B);
        return v[27:4];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        int g;
        if (jitter) begin
            g = $urandom_range(1, 5);
            repeat (g) begin
                @(negedge clk_i);
                adat_valid_i = 1'b0;
            end
        end
        @(negedge clk_i);
        line         = line ^ b;
        adat_i       = line;
        adat_valid_i = 1'b1;
    endtask

    task automatic send_frame(input logic [3:0] user, input int nz, input int bad, input int key);
        logic [23:0] w;
        repeat (nz) send_bit(1'b0);
        send_bit(1'b1);
        for (int i = 3; i >= 0; i--) send_bit(user[i]);
        for (int ch = 0; ch < 8; ch++) begin
            w = img(key, ch);
            for (int n = 0; n < 6; n++) begin
                if (ch * 6 + n == bad) begin
                    @(posedge clk_i); #1;
                    check("lock_before_bad_sep", 32'(locked_o), 32'd1);
                    send_bit(1'b0);
                    @(posedge clk_i); #1;
                    check("lock_drop_after_bad_sep", 32'(locked_o), 32'd0);
                end else begin
                    send_bit(1'b1);
                end
                for (int k = 0; k < 4; k++) send_bit(w[4*n+k]);
            end
        end
        send_bit(1'b1);
    endtask

    task automatic check_slot(input string tag, input logic [2:0] slot, input int key);
        int bad_bits;
        logic [23:0] w;
        bad_bits = 0;
        for (int ch = 0; ch < 8; ch++) begin
            w = img(key, ch);
            for (int p = 0; p < 24; p++) begin
                if (ram[{slot, 3'(ch), 5'(p)}] !== w[p]) bad_bits++;
            end
        end
        check({tag, " ram"}, 32'(bad_bits), 32'd0);
    endtask

    task automatic apply_vec(input vec_t v, input string tag, input bit prev_good);
        if (v.exp_done) begin
            for (int a = 0; a < 256; a++) ram[{v.exp_idx, 8'(a)}] = 1'bx;
        end
        send_frame(v.user, v.nz, v.bad, v.key);
        @(posedge clk_i); #1;
        check({tag, " frame_done"}, 32'(frame_done_o), 32'(v.exp_done));
        check({tag, " locked"}, 32'(locked_o), 32'(v.exp_locked));
        check({tag, " idx"}, 32'(last_good_frame_idx_o), 32'(v.exp_idx));
        check({tag, " user"}, 32'(user_bits_o), 32'(v.exp_user));
        if (frame_done_o) begin
            if (!jitter && prev_good) check({tag, " done_gap"}, 32'(cyc - last_done_cyc), 32'd256);
            last_done_cyc = cyc;
        end
        if (v.exp_done) check_slot(tag, v.exp_idx, v.key);
    endtask

    task automatic run_table(input string pfx);
        bit prev_good;
        prev_good = 1'b0;
        for (int i = 0; i < NV; i++) begin
            apply_vec(vecs[i], $sformatf("%s v%0d", pfx, i), prev_good);
            prev_good = vecs[i].exp_done;
        end
        @(negedge clk_i);
        adat_valid_i = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_ni       = 1'b0;
        adat_valid_i = 1'b0;
        repeat (3) @(negedge clk_i);
        rst_ni = 1'b1;
        line   = 1'b0;
        adat_i = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " wr_en"}, 32'(wr_en_o), 32'd0);
        check({tag, " write_data"}, 32'(write_data_o), 32'd0);
        check({tag, " write_addr"}, 32'(write_addr_o), 32'd0);
        check({tag, " idx"}, 32'(last_good_frame_idx_o), 32'd0);
        check({tag, " user"}, 32'(user_bits_o), 32'd0);
        check({tag, " frame_done"}, 32'(frame_done_o), 32'd0);
        check({tag, " locked"}, 32'(locked_o), 32'd0);
    endtask

    initial begin
        vec_t v;
        logic [23:0] w;
        int ch;
        int n;

        //         user  nz  bad key done lock idx   user
        vecs[0]  = '{4'h3, 10, -1,  0, 1'b1, 1'b1, 3'd0, 4'h3};
        vecs[1]  = '{4'h5, 10, -1,  1, 1'b1, 1'b1, 3'd1, 4'h5};
        vecs[2]  = '{4'hC, 10, -1,  2, 1'b1, 1'b1, 3'd2, 4'hC};
        vecs[3]  = '{4'h0, 10, -1,  3, 1'b1, 1'b1, 3'd3, 4'h0};
        vecs[4]  = '{4'hF, 10, -1,  4, 1'b1, 1'b1, 3'd4, 4'hF};
        vecs[5]  = '{4'h6, 10, -1,  5, 1'b1, 1'b1, 3'd5, 4'h6};
        vecs[6]  = '{4'h9, 10, -1,  6, 1'b1, 1'b1, 3'd6, 4'h9};
        vecs[7]  = '{4'h1, 10, -1,  7, 1'b1, 1'b1, 3'd7, 4'h1};
        vecs[8]  = '{4'hA, 10, -1,  8, 1'b1, 1'b1, 3'd0, 4'hA};  // slot wraps
        vecs[9]  = '{4'h7, 10, 20,  9, 1'b0, 1'b0, 3'd0, 4'hA};  // ch3 nibble2 separator = 0
        vecs[10] = '{4'hE, 10, -1, 10, 1'b1, 1'b1, 3'd1, 4'hE};  // rewrites slot 1
        vecs[11] = '{4'h2, 11, -1, 11, 1'b0, 1'b0, 3'd1, 4'hE};  // 11 sync zeros
        vecs[12] = '{4'hB, 10, -1, 12, 1'b1, 1'b1, 3'd2, 4'hB};
        vecs[13] = '{4'h4,  9, -1, 13, 1'b0, 1'b0, 3'd2, 4'hB};  // 1 inside sync window
        vecs[14] = '{4'hD, 10, -1, 14, 1'b1, 1'b1, 3'd3, 4'hD};

        // Reset state
        repeat (3) @(posedge clk_i);
        #1;
        check_all_zero("reset");
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Idle with no strobes
        repeat (100) @(negedge clk_i);
        check("idle wr_count", 32'(wr_count), 32'd0);
        check("idle done_count", 32'(done_count), 32'd0);
        check_all_zero("idle");

        // Continuous strobe
        jitter = 1'b0;
        run_table("cont");

        // Sparse jittered strobe, same expectations from a fresh reset
        do_reset();
        jitter = 1'b1;
        run_table("jit");

        // Reset in the middle of a frame
        jitter = 1'b0;
        do_reset();
        v = '{4'h5, 10, -1, 20, 1'b1, 1'b1, 3'd0, 4'h5};
        apply_vec(v, "mid f0", 1'b0);
        v = '{4'h6, 10, -1, 21, 1'b1, 1'b1, 3'd1, 4'h6};
        apply_vec(v, "mid f1", 1'b1);
        repeat (SYNC_ZEROS) send_bit(1'b0);
        send_bit(1'b1);
        for (int i = 3; i >= 0; i--) send_bit(1'b1);
        for (int g = 0; g < 21; g++) begin
            ch = g / 6;
            n  = g % 6;
            w  = img(22, ch);
            send_bit(1'b1);
            for (int k = 0; k < 4; k++) send_bit(w[4*n+k]);
        end
        send_bit(1'b1);              // bit 120 of the frame
        rst_ni = 1'b0;
        @(posedge clk_i); #1;
        check_all_zero("midrst");
        wr_count = 0;
        repeat (3) send_bit(1'b1);
        @(posedge clk_i); #1;
        check("midrst wr_count", 32'(wr_count), 32'd0);
        @(negedge clk_i);
        adat_valid_i = 1'b0;
        rst_ni = 1'b1;
        line   = 1'b0;
        adat_i = 1'b0;
        v = '{4'h9, 10, -1, 23, 1'b1, 1'b1, 3'd0, 4'h9};
        apply_vec(v, "after_rst", 1'b0);
        @(negedge clk_i);
        adat_valid_i = 1'b0;
        repeat (2) @(negedge clk_i);

        check("bitpos 24..31 writes", 32'(hi_writes), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
